// File: rtl/kbd_repeat.sv
// kbd_repeat: N-channel key front end.
// Each channel synchronises its raw key line, debounces press and release,
// and emits one-cycle press/release pulses. While a key is held, the channel
// can also emit typematic auto-repeat press pulses.
//
// Ports:
//   clk           system clock
//   rst           synchronous active-high reset
//   kbd[N]        raw key levels (1 = pressed), asynchronous to clk
//   repeat_en[N]  per-channel auto-repeat enable, synchronous to clk
//   press_pulse   one-cycle pulse per accepted press and per repeat
//   release_pulse one-cycle pulse per accepted release
//   held          debounced key level
//   any_press     OR of press_pulse, aligned with press_pulse
module kbd_repeat #(
  parameter int N             = 4,
  parameter int DEBOUNCE      = 250000,
  parameter int REPEAT_DELAY  = 12500000,
  parameter int REPEAT_PERIOD = 2500000,
  parameter int CNT_W         = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] kbd,
  input  logic [N-1:0] repeat_en,
  output logic [N-1:0] press_pulse,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] held,
  output logic         any_press
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HOLD_DELAY,
    HOLD_REPEAT,
    DEB_RELEASE
  } state_t;

  // Next-cycle press pulses of all channels, so any_press can be registered
  // in the same cycle as the individual pulses.
  logic [N-1:0] press_vec_next;
  logic         any_reg;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_ch
      logic             sync_reg;
      logic             kbd_s_reg;
      state_t           state_reg, state_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic             press_reg, press_next;
      logic             release_reg, release_next;
      logic             held_reg, held_next;

      always_ff @(posedge clk) begin
        if (rst) begin
          sync_reg    <= 1'b0;
          kbd_s_reg   <= 1'b0;
          state_reg   <= IDLE;
          cnt_reg     <= '0;
          press_reg   <= 1'b0;
          release_reg <= 1'b0;
          held_reg    <= 1'b0;
        end else begin
          sync_reg    <= kbd[gi];
          kbd_s_reg   <= sync_reg;
          state_reg   <= state_next;
          cnt_reg     <= cnt_next;
          press_reg   <= press_next;
          release_reg <= release_next;
          held_reg    <= held_next;
        end
      end

      // Precedence in every state: key level, then repeat enable, then the
      // counter terminal. The counter is cleared on every transition and at
      // each terminal count, so it never wraps.
      always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        press_next   = 1'b0;
        release_next = 1'b0;
        held_next    = held_reg;
        case (state_reg)
          IDLE: begin
            held_next = 1'b0;
            cnt_next  = '0;
            if (kbd_s_reg) begin
              state_next = DEB_PRESS;
            end
          end
          DEB_PRESS: begin
            if (!kbd_s_reg) begin
              state_next = IDLE;
              cnt_next   = '0;
            end else if (cnt_reg == DEB_LAST) begin
              state_next = HOLD_DELAY;
              press_next = 1'b1;
              held_next  = 1'b1;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          HOLD_DELAY: begin
            if (!kbd_s_reg) begin
              state_next = DEB_RELEASE;
              cnt_next   = '0;
            end else if (!repeat_en[gi]) begin
              cnt_next = '0;
            end else if (cnt_reg == DLY_LAST) begin
              state_next = HOLD_REPEAT;
              press_next = 1'b1;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          HOLD_REPEAT: begin
            if (!kbd_s_reg) begin
              state_next = DEB_RELEASE;
              cnt_next   = '0;
            end else if (!repeat_en[gi]) begin
              // Dropping the enable restarts the full repeat delay.
              state_next = HOLD_DELAY;
              cnt_next   = '0;
            end else if (cnt_reg == PER_LAST) begin
              press_next = 1'b1;
              cnt_next   = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          DEB_RELEASE: begin
            if (kbd_s_reg) begin
              // Release bounce: back to holding, repeat delay restarts.
              state_next = HOLD_DELAY;
              cnt_next   = '0;
            end else if (cnt_reg == DEB_LAST) begin
              state_next   = IDLE;
              release_next = 1'b1;
              held_next    = 1'b0;
              cnt_next     = '0;
            end else begin
              cnt_next = cnt_reg + CNT_W'(1);
            end
          end
          default: begin
            state_next = IDLE;
            cnt_next   = '0;
            held_next  = 1'b0;
          end
        endcase
      end

      assign press_vec_next[gi] = press_next;
      assign press_pulse[gi]    = press_reg;
      assign release_pulse[gi]  = release_reg;
      assign held[gi]           = held_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      any_reg <= 1'b0;
    end else begin
      any_reg <= |press_vec_next;
    end
  end

  assign any_press = any_reg;

endmodule
